// File: rtl/crc16_tx_encoder_if.sv
// Handshake/serial bundle for crc16_tx_encoder.
//   in_valid/in_ready/in_data : payload word handshake (driver -> encoder)
//   err_inj                   : corrupt transmitted CRC bit 0 (only with CRC_ERR_INJ_EN)
//   tx_bit/tx_valid/tx_last   : serial frame output (encoder -> sink)
//   crc_out                   : CRC of the last completed payload
//   busy                      : frame in progress
// Modports: master = word source / frame sink, slave = encoder.
interface crc16_tx_if #(
  parameter int unsigned DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
`ifdef CRC_ERR_INJ_EN
  logic              err_inj;
`endif
  logic              tx_bit;
  logic              tx_valid;
  logic              tx_last;
  logic [15:0]       crc_out;
  logic              busy;

  modport master (
    output in_valid,
    output in_data,
`ifdef CRC_ERR_INJ_EN
    output err_inj,
`endif
    input  in_ready,
    input  tx_bit,
    input  tx_valid,
    input  tx_last,
    input  crc_out,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  in_data,
`ifdef CRC_ERR_INJ_EN
    input  err_inj,
`endif
    output in_ready,
    output tx_bit,
    output tx_valid,
    output tx_last,
    output crc_out,
    output busy
  );
endinterface

// File: rtl/crc16_tx_encoder.sv
// Serial CRC-16 transmitter. Accepts a DATA_W-bit word, shifts it out MSB-first one bit per
// clock, then appends the 16-bit CRC (generator POLY, preset INIT) MSB-first.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-low reset
//   bus  : crc16_tx_if.slave (in_valid/in_ready/in_data, tx_bit/tx_valid/tx_last,
//          crc_out, busy; err_inj when CRC_ERR_INJ_EN is defined)
// Optional feature macro: CRC_ERR_INJ_EN adds err_inj, which inverts the final transmitted
// CRC bit of the accepted frame while crc_out keeps the true CRC.
// The interface DATA_W must match this module's DATA_W.
module crc16_tx_encoder #(
  parameter int unsigned DATA_W = 32,
  parameter logic [15:0] POLY   = 16'h1021,
  parameter logic [15:0] INIT   = 16'h0000
) (
  input logic       clk,
  input logic       rst,
  crc16_tx_if.slave bus
);

  localparam int unsigned CntMax = (DATA_W > 16) ? DATA_W : 16;
  localparam int unsigned CntW   = $clog2(CntMax);
  localparam logic [CntW-1:0] LastData  = CntW'(DATA_W - 1);
  localparam logic [CntW-1:0] LastCrc   = CntW'(15);
  localparam logic [CntW-1:0] PenultCrc = CntW'(14);

  typedef enum logic [1:0] {StIdle, StData, StCrc} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [15:0]       crc_q, crc_d;
  logic [15:0]       crc_out_q, crc_out_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              tx_bit_q, tx_bit_d;
  logic              tx_valid_q, tx_valid_d;
  logic              tx_last_q, tx_last_d;
  logic [15:0]       crc_step;
`ifdef CRC_ERR_INJ_EN
  logic              err_q, err_d;
`endif

  // One LFSR step using the bit currently on the line.
  assign crc_step = {crc_q[14:0], 1'b0} ^ ((tx_bit_q ^ crc_q[15]) ? POLY : 16'h0000);

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    crc_d      = crc_q;
    crc_out_d  = crc_out_q;
    cnt_d      = cnt_q;
    tx_bit_d   = 1'b0;
    tx_valid_d = 1'b0;
    tx_last_d  = 1'b0;
`ifdef CRC_ERR_INJ_EN
    err_d      = err_q;
`endif
    case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          // The MSB goes straight to the output register; the rest waits pre-shifted.
          tx_bit_d   = bus.in_data[DATA_W-1];
          tx_valid_d = 1'b1;
          shift_d    = bus.in_data << 1;
          crc_d      = INIT;
          cnt_d      = '0;
          state_d    = StData;
`ifdef CRC_ERR_INJ_EN
          err_d      = bus.err_inj;
`endif
        end
      end
      StData: begin
        tx_valid_d = 1'b1;
        if (cnt_q == LastData) begin
          crc_out_d = crc_step;
          // crc_q is free during the CRC phase, so it doubles as the CRC shift-out register.
          crc_d     = {crc_step[14:0], 1'b0};
          tx_bit_d  = crc_step[15];
          cnt_d     = '0;
          state_d   = StCrc;
        end else begin
          crc_d    = crc_step;
          tx_bit_d = shift_q[DATA_W-1];
          shift_d  = shift_q << 1;
          cnt_d    = cnt_q + CntW'(1);
        end
      end
      StCrc: begin
        if (cnt_q == LastCrc) begin
          state_d = StIdle;
        end else begin
          tx_valid_d = 1'b1;
          tx_bit_d   = crc_q[15];
          crc_d      = crc_q << 1;
          cnt_d      = cnt_q + CntW'(1);
          if (cnt_q == PenultCrc) begin
            tx_last_d = 1'b1;
`ifdef CRC_ERR_INJ_EN
            tx_bit_d  = crc_q[15] ^ err_q;
`endif
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      crc_q      <= INIT;
      crc_out_q  <= 16'h0000;
      cnt_q      <= '0;
      tx_bit_q   <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_last_q  <= 1'b0;
`ifdef CRC_ERR_INJ_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      crc_q      <= crc_d;
      crc_out_q  <= crc_out_d;
      cnt_q      <= cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_valid_q <= tx_valid_d;
      tx_last_q  <= tx_last_d;
`ifdef CRC_ERR_INJ_EN
      err_q      <= err_d;
`endif
    end
  end

  // Gated by rst so nothing is offered during the reset cycle.
  assign bus.in_ready = rst && (state_q == StIdle);
  assign bus.tx_bit   = tx_bit_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.tx_last  = tx_last_q;
  assign bus.crc_out  = crc_out_q;
  assign bus.busy     = (state_q != StIdle);

endmodule

// File: doc/crc16_tx_encoder.md
# crc16_tx_encoder

Serial CRC-16 transmitter that pairs with the serial CRC-16 checker. It accepts a 32-bit data word over a valid/ready handshake and shifts it out MSB-first, one bit per clock. It then appends the 16-bit remainder of the CCITT polynomial x^16+x^12+x^5+1 (0x1021, init 0x0000), also MSB-first. The 48-bit serial frame feeds the checker's LFSR directly, which must finish at remainder 0x0000 for an error-free frame.

## Interface

Parameters:
- DATA_W, 32, payload width in bits; must be ≥ 1
- POLY, 16'h1021, CRC generator polynomial (x^16 term implicit)
- INIT, 16'h0000, CRC register value loaded at the start of each frame

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset; one clock, synchronous, active-low
- in_valid  input  1  in_data is valid
- in_ready  output  1  block can accept a word; high only in IDLE
- in_data  input  DATA_W  payload word
- tx_bit  output  1  serial output bit
- tx_valid  output  1  tx_bit carries a frame bit this cycle
- tx_last  output  1  tx_bit is the final CRC bit of the frame
- crc_out  output  16  CRC of the last completed payload; held until the next payload is accepted
- busy  output  1  frame in progress (state ≠ IDLE)

## Operation

- State machine: IDLE, DATA, CRC.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: load shift register with in_data, crc_reg←INIT, bit counter←0, go to DATA.
- DATA (DATA_W cycles): each cycle tx_bit = shift[DATA_W-1] and tx_valid=1.
  - CRC update: fb = tx_bit ^ crc_reg[15]; crc_reg ← {crc_reg[14:0],1'b0} ^ (fb ? POLY : 0).
  - Shift left; counter++.
  - After the bit at counter = DATA_W-1: crc_out←updated crc_reg, counter←0, go to CRC.
- CRC (16 cycles): tx_bit = crc_out[15-counter], tx_valid=1, crc_reg not updated.
  - tx_last=1 when counter=15.
  - After that bit, go to IDLE.
- Outputs tx_bit, tx_valid and tx_last are registered.
  - tx_bit=0 whenever tx_valid=0.
  - tx_last is never high without tx_valid.
- in_data and in_valid are ignored outside IDLE. No input buffering.
- There is no output backpressure: the frame always streams contiguously for DATA_W+16 cycles.

## Timing

- Reset values: in_ready=0 during the reset cycle, then 1. tx_bit=0, tx_valid=0, tx_last=0, crc_out=16'h0000, busy=0. State=IDLE.
- Reset asserted mid-frame: the frame aborts. On the next edge all outputs return to their reset values and no tx_last is produced.
- Latency:
  - Handshake at edge N.
  - First payload bit on tx_bit in cycle N+1.
  - Last payload bit in cycle N+DATA_W.
  - CRC bits in cycles N+DATA_W+1 through N+DATA_W+16, with tx_last in cycle N+DATA_W+16.
  - crc_out updates at the edge ending cycle N+DATA_W.
- in_ready rises in the cycle after tx_last. Minimum frame period is DATA_W+17 cycles. With in_valid held high, a gap of exactly one idle cycle separates frames.
- crc_out is stable throughout the CRC phase and until the next accepted word.

## Configuration

- CRC_ERR_INJ_EN defined:
  - Adds input port err_inj (1 bit), sampled with the in_valid&&in_ready handshake.
  - If err_inj=1, bit 0 of the transmitted CRC is inverted, i.e. the tx_last bit. crc_out still reports the true CRC.
  - The checker must then report a nonzero remainder.
- CRC_ERR_INJ_EN undefined: no err_inj port, and the transmitted CRC always equals crc_out.

## Test plan

- Reset: hold rst=0 for 3 cycles with in_valid=1 -> tx_valid=0, crc_out=0x0000, busy=0, no word accepted. After release, in_ready=1.
- in_data=0x00000001 -> 31 zeros, then 1, then CRC bits 0001000000100001 (0x1021). tx_last only on the 48th bit, crc_out=0x1021, in_ready high one cycle later.
- in_data=0x00000003, then 0x00000000, with in_valid held high -> the first frame carries CRC 0x3063. The second frame starts exactly one idle cycle after tx_last and sends 48 zero bits with crc_out=0x0000.
- Loopback: stream the frame for in_data=0x4841DC80 into the CRC-16 checker -> checker remainder is 0x0000 after 48 bits. Repeat with 100 random words: always 0x0000.
- Reset mid-frame: assert rst at payload bit 10 -> next cycle tx_valid=0, busy=0, no tx_last. The following frame for 0x00000002 yields CRC 0x2042.
- With CRC_ERR_INJ_EN: in_data=0x00000001, err_inj=1 -> transmitted CRC 0x1020, crc_out=0x1021, checker remainder nonzero.
